// File: rtl/fir_output_requantizer_if.sv
// fir_output_requantizer_if: sample handshakes of the FIR output requantizer.
// Input side (in_*) and output side (out_*) valid/ready pairs in one bundle.
interface fir_output_requantizer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16
);
  logic                        in_valid;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_ready;
  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/fir_output_requantizer.sv
// fir_output_requantizer: round, shift, saturate FIR accumulator into a FIFO.
// Optional FIR_REQUANT_SAT_COUNT_EN adds a saturating clip counter port.
module fir_output_requantizer #(
  parameter  int IN_WIDTH  = 32,
  parameter  int OUT_WIDTH = 16,
  parameter  int SHIFT     = 15,
  parameter  int DEPTH     = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  fir_output_requantizer_if.slave bus,
  output logic                    sat_flag,
`ifdef FIR_REQUANT_SAT_COUNT_EN
  output logic [15:0]             sat_count,
`endif
  output logic [LW-1:0]           fifo_level
);

  localparam int PW = IN_WIDTH + 1;

  localparam logic [PW-1:0] RND =
    {{(PW-1){1'b0}}, 1'b1} << (SHIFT - 1);

  localparam logic signed [PW-1:0] QMAX =
    $signed({{(PW-OUT_WIDTH+1){1'b0}},
             {(OUT_WIDTH-1){1'b1}}});

  localparam logic signed [PW-1:0] QMIN =
    $signed({{(PW-OUT_WIDTH+1){1'b1}},
             {(OUT_WIDTH-1){1'b0}}});

  localparam logic [OUT_WIDTH-1:0] OMAX =
    {1'b0, {(OUT_WIDTH-1){1'b1}}};

  localparam logic [OUT_WIDTH-1:0] OMIN =
    {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] sum;
  } s1_t;

  s1_t                   s1_q;
  logic [OUT_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic [LW:0]           credit;
  logic [PW-1:0]         sext;
  logic signed [PW-1:0]  q;
  logic [OUT_WIDTH-1:0]  clip;
  logic                  clipped;
  logic                  accept;
  logic                  push;
  logic                  pop;

  assign sext = {bus.in_data[IN_WIDTH-1], bus.in_data};

  // Samples in S1 already hold a FIFO slot, so count them as used.
  assign credit = {1'b0, level} + {{LW{1'b0}}, s1_q.vld};

  assign bus.in_ready  = credit < (LW+1)'(DEPTH);
  assign accept        = bus.in_valid & bus.in_ready;
  assign push          = s1_q.vld;
  assign bus.out_valid = level != '0;
  assign pop           = bus.out_valid & bus.out_ready;
  assign fifo_level    = level;

  assign bus.out_data =
    bus.out_valid ? $signed(mem[rd_ptr])
                  : '0;

  // S2: arithmetic shift of the rounded sum, then clip to output range.
  always_comb begin
    q       = $signed(s1_q.sum) >>> SHIFT;
    clip    = q[OUT_WIDTH-1:0];
    clipped = 1'b0;
    unique case (1'b1)
      (q > QMAX): begin
        clip    = OMAX;
        clipped = 1'b1;
      end
      (q < QMIN): begin
        clip    = OMIN;
        clipped = 1'b1;
      end
      default: ;
    endcase
  end

  // S1: register the rounded sum of each accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q.vld <= accept;
      if (accept) begin
        s1_q.sum <= sext + RND;
      end
    end
  end

  // FIFO storage: S2 result is written as it leaves the pipeline.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= clip;
    end
  end

  // FIFO pointers and occupancy; credit flow keeps push from overflowing.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Clip indication, one pulse per clipped sample entering the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= push & clipped;
    end
  end

`ifdef FIR_REQUANT_SAT_COUNT_EN
  // Clip counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_flag && sat_count != 16'hFFFF) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule
